// File: rtl/pll_reset_sequencer.sv
// Holds downstream logic in reset until PLL lock has been stable for a qualified time.
// Also generates run-time-selectable clock-enable strobes while running.
module pll_reset_sequencer #(
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_CE      = 2,
  parameter int DIV_W       = 8,
  parameter int CNT_W       = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      pll_locked,
  input  logic [NUM_CE*DIV_W-1:0]   div,
  output logic                      sys_reset,
  output logic                      ready,
  output logic [NUM_CE-1:0]         ce,
  output logic [CNT_W-1:0]          loss_count
);

  localparam int LC_W = $clog2(LOCK_CYCLES + 1);
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, HOLD, RUN} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                sync_q, sync_d;
  logic [LC_W-1:0]           lock_cnt_q, lock_cnt_d;
  logic [HC_W-1:0]           hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]          loss_q, loss_d;
  logic                      sys_reset_q, sys_reset_d;
  logic                      ready_q, ready_d;
  logic [NUM_CE-1:0]         ce_q, ce_d;
  logic [NUM_CE*DIV_W-1:0]   div_q, div_d;
  logic [NUM_CE*DIV_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic                      run_entry;
  logic                      lk;

  assign lk = sync_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_LOCK;
      sync_q      <= '0;
      lock_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      loss_q      <= '0;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      ce_q        <= '0;
      div_q       <= '0;
      ch_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      lock_cnt_q  <= lock_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      loss_q      <= loss_d;
      sys_reset_q <= sys_reset_d;
      ready_q     <= ready_d;
      ce_q        <= ce_d;
      div_q       <= div_d;
      ch_cnt_q    <= ch_cnt_d;
    end
  end

  always_comb begin
    sync_d     = {sync_q[0], pll_locked};
    state_d    = state_q;
    lock_cnt_d = '0;
    hold_cnt_d = '0;
    loss_d     = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lk) begin
          state_d    = QUALIFY;
          lock_cnt_d = LC_W'(1);
        end
      end
      QUALIFY: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
        end else if (lock_cnt_q == LC_W'(LOCK_CYCLES)) begin
          state_d    = HOLD;
          hold_cnt_d = HC_W'(1);
        end else begin
          lock_cnt_d = lock_cnt_q + LC_W'(1);
        end
      end
      HOLD: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
        end else if (hold_cnt_q == HC_W'(HOLD_CYCLES)) begin
          state_d = RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      RUN: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          loss_d  = (&loss_q) ? loss_q : loss_q + CNT_W'(1);
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Outputs are derived from the next state so they register on the same edge as the transition.
  always_comb begin
    run_entry   = (state_q != RUN) && (state_d == RUN);
    div_d       = run_entry ? div : div_q;
    sys_reset_d = (state_d != RUN);
    ready_d     = (state_d == RUN);
  end

  generate
    for (genvar gi = 0; gi < NUM_CE; gi++) begin : g_ce
      logic [DIV_W-1:0] d_val;
      logic [DIV_W-1:0] cnt_cur;
      logic [DIV_W-1:0] cnt_nxt;
      logic             ce_nxt;

      // Counter restarts at 0 on the first RUN cycle; strobe fires when it reaches d-1.
      always_comb begin
        d_val   = div_d[gi*DIV_W +: DIV_W];
        cnt_cur = ch_cnt_q[gi*DIV_W +: DIV_W];
        cnt_nxt = '0;
        if ((state_q == RUN) && (state_d == RUN) && (d_val > DIV_W'(1)) &&
            (cnt_cur != d_val - DIV_W'(1))) begin
          cnt_nxt = cnt_cur + DIV_W'(1);
        end
        ce_nxt = (state_d == RUN) &&
                 ((d_val <= DIV_W'(1)) || (cnt_nxt == d_val - DIV_W'(1)));
      end

      assign ch_cnt_d[gi*DIV_W +: DIV_W] = cnt_nxt;
      assign ce_d[gi]                    = ce_nxt;
    end
  endgenerate

  assign sys_reset  = sys_reset_q;
  assign ready      = ready_q;
  assign ce         = ce_q;
  assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: lock qualification, lock loss, CE strobes,
// loss-count saturation and asynchronous reset.
module tb_pll_reset_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        pll_locked;
  logic [15:0] div;
  logic        sys_reset;
  logic        ready;
  logic [1:0]  ce;
  logic [1:0]  loss_count;

  pll_reset_sequencer #(
    .LOCK_CYCLES(8),
    .HOLD_CYCLES(4),
    .NUM_CE(2),
    .DIV_W(8),
    .CNT_W(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .div(div),
    .sys_reset(sys_reset),
    .ready(ready),
    .ce(ce),
    .loss_count(loss_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       sr;
    logic       rdy;
    logic [1:0] ce;
    logic [1:0] loss;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_d0, exp_d1, run_c, exp_loss;

  function automatic logic ce_exp(int d, int c);
    if (d <= 1) return 1'b1;
    return (c % d) == (d - 1);
  endfunction

  task automatic push_exp(logic sr, logic rdy, logic [1:0] c);
    exp_t e;
    e.sr   = sr;
    e.rdy  = rdy;
    e.ce   = c;
    e.loss = 2'(exp_loss);
    sb.push_back(e);
  endtask

  task automatic compare(string tag);
    exp_t e;
    exp_t o;
    e = sb.pop_front();
    o.sr   = sys_reset;
    o.rdy  = ready;
    o.ce   = ce;
    o.loss = loss_count;
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed sr/rdy/ce/loss=%b expected %b", tag, o, e);
    end
    $display("[%0t] %s: sr=%b rdy=%b ce=%b loss=%0d", $time, tag, o.sr, o.rdy, o.ce, o.loss);
  endtask

  task automatic step(logic sr, logic rdy, logic [1:0] c, string tag);
    push_exp(sr, rdy, c);
    @(posedge clock);
    #1;
    compare(tag);
  endtask

  // pll_locked must already be high for the next edge; RUN is reached 14 edges later.
  task automatic lock_sequence(string tag);
    exp_d0 = int'(div[7:0]);
    exp_d1 = int'(div[15:8]);
    for (int k = 0; k < 14; k++) step(1'b1, 1'b0, 2'b00, tag);
    step(1'b0, 1'b1, {ce_exp(exp_d1, 0), ce_exp(exp_d0, 0)}, tag);
    run_c = 1;
  endtask

  task automatic run_cycles(int n, string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, {ce_exp(exp_d1, run_c), ce_exp(exp_d0, run_c)}, tag);
      run_c++;
    end
  endtask

  // Drop lock for three sampled edges while in RUN, then relock.
  task automatic lose_lock(string tag);
    pll_locked = 1'b0;
    run_cycles(2, tag);
    exp_loss = (exp_loss >= 3) ? 3 : exp_loss + 1;
    step(1'b1, 1'b0, 2'b00, tag);
    pll_locked = 1'b1;
    lock_sequence(tag);
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    div        = {8'd1, 8'd3};
    exp_loss   = 0;
    run_c      = 0;
    exp_d0     = 0;
    exp_d1     = 0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, "reset_state");

    reset_n    = 1'b1;
    pll_locked = 1'b1;
    lock_sequence("lock_up");
    run_cycles(4, "run_div_3_1");

    div = {8'd5, 8'd5};
    run_cycles(5, "run_div_ignored");

    lose_lock("loss_1");
    run_cycles(10, "run_div_5_5");

    for (int i = 0; i < 4; i++) begin
      lose_lock("loss_sat");
      run_cycles(3, "loss_sat_run");
    end

    #2 reset_n = 1'b0;
    exp_loss = 0;
    #1;
    push_exp(1'b1, 1'b0, 2'b00);
    compare("async_reset");
    #1 reset_n = 1'b1;
    lock_sequence("relock");
    run_cycles(2, "relock_run");

    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 2'b00, "qual_glitch");
    pll_locked = 1'b0;
    step(1'b1, 1'b0, 2'b00, "qual_glitch");
    pll_locked = 1'b1;
    lock_sequence("qual_glitch");
    run_cycles(6, "qual_glitch_run");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
